// File: rtl/stopwatch_pkg.sv
// Shared constants for the mm:ss stopwatch controller:
// FSM state codes, BCD digit limits and the long-clear hold multiplier.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  localparam logic [3:0] DIG_MAX9 = 4'd9;
  localparam logic [3:0] DIG_MAX5 = 4'd5;

  localparam int LONG_CLR_MULT = 2;

endpackage

// File: rtl/stopwatch_ctrl_one_pulse.sv
// Level to single-cycle rising-edge pulse; history resets to 1 so a
// button held through reset stays silent until released and pressed.
module one_pulse (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= i_lvl;
  end

  assign o_pulse = i_lvl & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button pulses, 4-state FSM, 1 Hz prescaler, BCD mm:ss.
// Optional LONG_CLR_EN: holding lap/clear for 2*TICK_DIV cycles forces IDLE.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic        pb_s_de,
  input  logic        pb_l_de,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic [1:0]  state
);

  import stopwatch_pkg::*;

  logic             w_press_s;
  logic             w_press_l;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [15:0]      r_count;
  logic [15:0]      r_lap;
  logic [15:0]      w_count_inc;
  logic [CNT_W-1:0] r_presc;
  logic             w_active;
  logic             w_tick;
  logic             w_cap;
  logic             w_clr;
  logic             w_long;

  one_pulse u_pulse_s (
    .clk     (clk_100),
    .rst     (rst),
    .i_lvl   (pb_s_de),
    .o_pulse (w_press_s)
  );

  one_pulse u_pulse_l (
    .clk     (clk_100),
    .rst     (rst),
    .i_lvl   (pb_l_de),
    .o_pulse (w_press_l)
  );

  assign w_active = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_tick   = w_active &&
                    (r_presc == CNT_W'(TICK_DIV - 1));

  // Ripple carry through ss then mm, each digit pair wrapping at 59.
  always_comb begin
    w_count_inc = r_count;
    if (r_count[3:0] != DIG_MAX9) begin
      w_count_inc[3:0] = r_count[3:0] + 4'd1;
    end else begin
      w_count_inc[3:0] = 4'd0;
      if (r_count[7:4] != DIG_MAX5) begin
        w_count_inc[7:4] = r_count[7:4] + 4'd1;
      end else begin
        w_count_inc[7:4] = 4'd0;
        if (r_count[11:8] != DIG_MAX9) begin
          w_count_inc[11:8] = r_count[11:8] + 4'd1;
        end else begin
          w_count_inc[11:8] = 4'd0;
          if (r_count[15:12] != DIG_MAX5)
            w_count_inc[15:12] = r_count[15:12] + 4'd1;
          else
            w_count_inc[15:12] = 4'd0;
        end
      end
    end
  end

  // Start/pause is tested first so it wins a simultaneous press.
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press_s) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_press_s) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_press_l) begin
          w_state_nxt = ST_LAP;
          w_cap       = 1'b1;
        end
      end
      ST_LAP: begin
        if (w_press_s)      w_state_nxt = ST_PAUSE;
        else if (w_press_l) w_state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (w_press_s) begin
          w_state_nxt = ST_RUN;
        end else if (w_press_l) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end
      end
    endcase
  end

`ifdef LONG_CLR_EN
  localparam int HOLD_LIM = LONG_CLR_MULT * TICK_DIV;

  logic [CNT_W+1:0] r_hold;

  always_ff @(posedge clk_100) begin
    if (rst || !pb_l_de)
      r_hold <= '0;
    else if (r_hold != (CNT_W+2)'(HOLD_LIM))
      r_hold <= r_hold + (CNT_W+2)'(1);
  end

  assign w_long = pb_l_de && (r_state != ST_IDLE) &&
                  (r_hold >= (CNT_W+2)'(HOLD_LIM - 1));
`else
  assign w_long = 1'b0;
`endif

  always_ff @(posedge clk_100) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_lap   <= '0;
      r_presc <= '0;
    end else if (w_long) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap) r_lap <= r_count;
      if (w_clr) begin
        r_count <= '0;
        r_presc <= '0;
      end else begin
        if (w_tick) r_count <= w_count_inc;
        if (w_active)
          r_presc <= w_tick ? '0 : r_presc + CNT_W'(1);
        else if (r_state == ST_IDLE)
          r_presc <= '0;
      end
    end
  end

  assign disp_bcd   = (r_state == ST_LAP) ? r_lap : r_count;
  assign running    = w_active;
  assign lap_active = (r_state == ST_LAP);
  assign state      = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl at TICK_DIV=4: directed scenarios plus a
// random run checked against a seconds-based reference model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pb_s = 1'b0;
  logic        pb_l = 1'b0;
  logic [15:0] disp_bcd;
  logic        running;
  logic        lap_active;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  int m_st, m_sec, m_lap, m_presc, m_hold;
  bit m_ps, m_pl;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .CNT_W(4)) dut (
    .clk_100    (clk),
    .rst        (rst),
    .pb_s_de    (pb_s),
    .pb_l_de    (pb_l),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .lap_active (lap_active),
    .state      (state)
  );

  function automatic logic [15:0] to_bcd(input int x);
    return {4'(x / 600), 4'((x / 60) % 10),
            4'((x % 60) / 10), 4'(x % 10)};
  endfunction

  function automatic logic [19:0] model_out();
    logic act;
    act = (m_st == 1) || (m_st == 3);
    return {2'(m_st), act, (m_st == 3),
            (m_st == 3) ? to_bcd(m_lap) : to_bcd(m_sec)};
  endfunction

  // Model in whole seconds; modes: 0 idle, 1 run, 2 pause, 3 lap.
  task automatic step(input logic s, input logic l, input logic r);
    bit ps, pl, act, tick, lng;
    int old_sec;
    pb_s = s;
    pb_l = l;
    rst  = r;
    ps = s && !m_ps;
    pl = l && !m_pl;
    if (r) begin
      m_st = 0; m_sec = 0; m_lap = 0; m_presc = 0;
      m_hold = 0; m_ps = 1; m_pl = 1;
    end else begin
      m_ps = s;
      m_pl = l;
      m_hold = l ? m_hold + 1 : 0;
      lng = 0;
`ifdef LONG_CLR_EN
      lng = (m_hold >= 2 * TD) && (m_st != 0);
`endif
      act  = (m_st == 1) || (m_st == 3);
      tick = act && (m_presc == TD - 1);
      old_sec = m_sec;
      if (lng) begin
        m_st = 0; m_sec = 0; m_presc = 0;
      end else begin
        if (act) m_presc = tick ? 0 : m_presc + 1;
        else if (m_st == 0) m_presc = 0;
        if (tick) m_sec = (m_sec + 1) % 3600;
        case (m_st)
          0: if (ps) m_st = 1;
          1: if (ps) m_st = 2;
             else if (pl) begin m_st = 3; m_lap = old_sec; end
          2: if (ps) m_st = 1;
             else if (pl) begin m_st = 0; m_sec = 0; m_presc = 0; end
          default: if (ps) m_st = 2; else if (pl) m_st = 1;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 1);
    step(1, 0, 1);
    n_checks++;
    if ({state, running, lap_active, disp_bcd} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset: got st=%0d run=%b lap=%b disp=%h want 0/0/0/0000",
               state, running, lap_active, disp_bcd);
    end
    repeat (10) step(1, 0, 0);
    n_checks++;
    if ({state, disp_bcd} !== 18'h0) begin
      n_fail++;
      $display("FAIL held_thru_reset: got st=%0d disp=%h want 0/0000",
               state, disp_bcd);
    end
    step(0, 0, 0);
    step(1, 0, 0);
    n_checks++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL press_after_release: got st=%0d want 1", state);
    end
  endtask

  task automatic test_run_wrap();
    do_reset();
    step(1, 0, 0);
    repeat (40) step(0, 0, 0);
    n_checks++;
    if ({running, disp_bcd} !== {1'b1, 16'h0010}) begin
      n_fail++;
      $display("FAIL run_40: got run=%b disp=%h want 1/0010",
               running, disp_bcd);
    end
    repeat ((3599 - 10) * TD) step(0, 0, 0);
    n_checks++;
    if (disp_bcd !== 16'h5959) begin
      n_fail++;
      $display("FAIL preload_5959: got %h want 5959", disp_bcd);
    end
    repeat (TD) step(0, 0, 0);
    n_checks++;
    if ({running, disp_bcd} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL wrap: got run=%b disp=%h want 1/0000",
               running, disp_bcd);
    end
  endtask

  task automatic test_lap();
    do_reset();
    step(1, 0, 0);
    repeat (12) step(0, 0, 0);
    step(0, 1, 0);
    n_checks++;
    if ({lap_active, state, disp_bcd} !== {1'b1, 2'd3, 16'h0003}) begin
      n_fail++;
      $display("FAIL lap_enter: got lap=%b st=%0d disp=%h want 1/3/0003",
               lap_active, state, disp_bcd);
    end
    repeat (8) step(0, 0, 0);
    n_checks++;
    if ({lap_active, disp_bcd} !== {1'b1, 16'h0003}) begin
      n_fail++;
      $display("FAIL lap_frozen: got lap=%b disp=%h want 1/0003",
               lap_active, disp_bcd);
    end
    step(0, 1, 0);
    n_checks++;
    if ({lap_active, state, disp_bcd} !== {1'b0, 2'd1, 16'h0005}) begin
      n_fail++;
      $display("FAIL lap_exit: got lap=%b st=%0d disp=%h want 0/1/0005",
               lap_active, state, disp_bcd);
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    n_checks++;
    if ({state, running, disp_bcd} !== {2'd2, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL pause: got st=%0d run=%b disp=%h want 2/0/0000",
               state, running, disp_bcd);
    end
    repeat (20) step(0, 0, 0);
    step(1, 0, 0);
    n_checks++;
    if ({state, disp_bcd} !== {2'd1, 16'h0000}) begin
      n_fail++;
      $display("FAIL resume: got st=%0d disp=%h want 1/0000",
               state, disp_bcd);
    end
    step(0, 0, 0);
    n_checks++;
    if (disp_bcd !== 16'h0001) begin
      n_fail++;
      $display("FAIL resume_partial: got %h want 0001", disp_bcd);
    end
  endtask

  task automatic test_simul_clear();
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    n_checks++;
    if ({state, disp_bcd} !== {2'd1, 16'h0001}) begin
      n_fail++;
      $display("FAIL simul_press: got st=%0d disp=%h want 1/0001",
               state, disp_bcd);
    end
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    n_checks++;
    if ({state, disp_bcd} !== {2'd0, 16'h0000}) begin
      n_fail++;
      $display("FAIL pause_clear: got st=%0d disp=%h want 0/0000",
               state, disp_bcd);
    end
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (TD) step(0, 0, 0);
    n_checks++;
    if (disp_bcd !== 16'h0001) begin
      n_fail++;
      $display("FAIL presc_cleared: got %h want 0001", disp_bcd);
    end
  endtask

  task automatic test_long_clr();
    do_reset();
    step(1, 0, 0);
    step(0, 0, 0);
`ifdef LONG_CLR_EN
    repeat (2 * TD - 1) step(0, 1, 0);
    n_checks++;
    if (state !== 2'd3) begin
      n_fail++;
      $display("FAIL long_pre: got st=%0d want 3", state);
    end
    step(0, 1, 0);
    n_checks++;
    if ({state, disp_bcd} !== {2'd0, 16'h0000}) begin
      n_fail++;
      $display("FAIL long_clr: got st=%0d disp=%h want 0/0000",
               state, disp_bcd);
    end
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (2 * TD - 1) step(0, 1, 0);
    step(0, 0, 0);
    n_checks++;
    if (state !== 2'd3) begin
      n_fail++;
      $display("FAIL long_short: got st=%0d want 3", state);
    end
`else
    repeat (2 * TD) step(0, 1, 0);
    n_checks++;
    if (state !== 2'd3) begin
      n_fail++;
      $display("FAIL no_long_clr: got st=%0d want 3", state);
    end
    step(0, 0, 0);
`endif
  endtask

  task automatic test_random();
    logic s, l, r;
    logic [19:0] exp_v;
    s = 1'b0;
    l = 1'b0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) s = ~s;
      if ($urandom_range(0, 7) == 0) l = ~l;
      r = ($urandom_range(0, 299) == 0);
      step(s, l, r);
      exp_v = model_out();
      n_checks++;
      if ({state, running, lap_active, disp_bcd} !== exp_v) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL random[%0d]: got %h want %h", i,
                   {state, running, lap_active, disp_bcd}, exp_v);
      end
    end
  endtask

  initial begin
    m_st = 0; m_sec = 0; m_lap = 0; m_presc = 0;
    m_hold = 0; m_ps = 1; m_pl = 1;
    test_reset();
    test_run_wrap();
    test_lap();
    test_pause_resume();
    test_simul_clear();
    test_long_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
